// File: rtl/ara_pkg.sv
// Shared lane constants for mask distribution: FU tag space, element type and index-width helper.
package ara_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [63:0] elen_t;

    // FU channel indices; new mask consumers are appended after the last entry
    localparam int unsigned MaskFUAlu    = 0;
    localparam int unsigned MaskFUMFpu   = 1;
    localparam int unsigned NrMaskFUnits = 2;

    typedef logic [idx_width(NrMaskFUnits)-1:0] mask_fu_tag_t;

endpackage

// File: rtl/vfu_mask_fifo.sv
// Single-channel mask FIFO with synchronous flush and occupancy count; any depth >= 1.
module vfu_mask_fifo
    import ara_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 8,
    localparam int unsigned PtrW = idx_width(Depth),
    localparam int unsigned CntW = idx_width(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [Width-1:0] wdata,
    input  logic            pop,
    output logic [Width-1:0] rdata,
    output logic            valid,
    output logic            full,
    output logic [CntW-1:0] cnt
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW-1:0]  wptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == CntW'(Depth));
    assign cnt     = cnt_q;
    assign pop_en  = pop & valid;
    // A push during flush is accepted upstream but never stored
    assign push_en = push & ~flush;
    assign rdata   = valid ? mem[rptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_en) wptr_q <= wrap_inc(wptr_q);
            if (pop_en)  rptr_q <= wrap_inc(rptr_q);
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/vfu_mask_router.sv
// Routes tagged mask beats from the mask unit to per-FU FIFOs.
// Optional combinational bypass for empty channels: define ARA_MASK_BYPASS_EN.
module vfu_mask_router
    import ara_pkg::*;
#(
    parameter int unsigned NrFUs        = NrMaskFUnits,
    parameter int unsigned MaskBufDepth = 2,
    parameter int unsigned DataWidth    = $bits(elen_t),
    localparam int unsigned StrbW = DataWidth / 8,
    localparam int unsigned TagW  = idx_width(NrFUs),
    localparam int unsigned CntW  = idx_width(MaskBufDepth + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [StrbW-1:0]                 mask_i,
    input  logic [TagW-1:0]                  mask_fu_i,
    input  logic                             mask_valid_i,
    output logic                             mask_ready_o,
    output logic [NrFUs-1:0][StrbW-1:0]      fu_mask_o,
    output logic [NrFUs-1:0]                 fu_mask_valid_o,
    input  logic [NrFUs-1:0]                 fu_mask_ready_i,
    input  logic [NrFUs-1:0]                 fu_flush_i,
    output logic [NrFUs-1:0][CntW-1:0]       fu_mask_cnt_o,
    output logic                             mask_err_o
);

    logic [NrFUs-1:0]            sel;
    logic [NrFUs-1:0]            push;
    logic [NrFUs-1:0]            fifo_valid;
    logic [NrFUs-1:0]            fifo_full;
    logic [NrFUs-1:0][StrbW-1:0] fifo_rdata;
    logic                        legal;
    logic                        err_q;

    // Ready depends only on the selected channel's fill state, never on FU ready
    always_comb begin
        mask_ready_o = 1'b1;
        legal        = 1'b0;
        sel          = '0;
        for (int i = 0; i < NrFUs; i++) begin
            if (mask_fu_i == TagW'(i)) begin
                legal        = 1'b1;
                mask_ready_o = ~fifo_full[i];
                sel[i]       = mask_valid_i;
            end
        end
    end

    for (genvar g = 0; g < NrFUs; g++) begin : gen_ch
`ifdef ARA_MASK_BYPASS_EN
        logic fwd;
        assign fwd                = sel[g] & ~fifo_valid[g] & ~fu_flush_i[g];
        assign fu_mask_valid_o[g] = fifo_valid[g] | fwd;
        assign fu_mask_o[g]       = fifo_valid[g] ? fifo_rdata[g] : (fwd ? mask_i : '0);
        assign push[g]            = sel[g] & ~fifo_full[g] & ~(fwd & fu_mask_ready_i[g]);
`else
        assign fu_mask_valid_o[g] = fifo_valid[g];
        assign fu_mask_o[g]       = fifo_rdata[g];
        assign push[g]            = sel[g] & ~fifo_full[g];
`endif

        vfu_mask_fifo #(
            .Depth (MaskBufDepth),
            .Width (StrbW)
        ) i_fifo (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .flush (fu_flush_i[g]),
            .push  (push[g]),
            .wdata (mask_i),
            .pop   (fu_mask_ready_i[g]),
            .rdata (fifo_rdata[g]),
            .valid (fifo_valid[g]),
            .full  (fifo_full[g]),
            .cnt   (fu_mask_cnt_o[g])
        );
    end

    // Illegal tags are consumed and dropped; the flag is sticky until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                     err_q <= 1'b0;
        else if (mask_valid_i && !legal) err_q <= 1'b1;
    end

    assign mask_err_o = err_q;

endmodule

// File: tb/tb_vfu_mask_router.sv
// Directed bench for vfu_mask_router with three FU channels of depth two.
module tb_vfu_mask_router;
    import ara_pkg::*;

    localparam int unsigned N = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        mask = '0;
    logic [1:0]        tag = '0;
    logic              mvalid = 1'b0;
    logic              mready;
    logic [N-1:0][7:0] fu_mask;
    logic [N-1:0]      fu_valid;
    logic [N-1:0]      fu_ready = '0;
    logic [N-1:0]      fu_flush = '0;
    logic [N-1:0][1:0] fu_cnt;
    logic              err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vfu_mask_router #(.NrFUs(N), .MaskBufDepth(2), .DataWidth(64)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .mask_i          (mask),
        .mask_fu_i       (tag),
        .mask_valid_i    (mvalid),
        .mask_ready_o    (mready),
        .fu_mask_o       (fu_mask),
        .fu_mask_valid_o (fu_valid),
        .fu_mask_ready_i (fu_ready),
        .fu_flush_i      (fu_flush),
        .fu_mask_cnt_o   (fu_cnt),
        .mask_err_o      (err)
    );

    task automatic push_beat(input logic [1:0] t, input logic [7:0] d);
        tag = t; mask = d; mvalid = 1'b1;
        @(posedge clk); #1;
        mvalid = 1'b0;
        #1;
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tag = 2'd0; mvalid = 1'b0;
        #12;
        checks++; if (fu_valid !== 3'b000) begin failures++; $display("FAIL reset_valid got %b exp 000", fu_valid); end
        checks++; if (fu_cnt !== 6'h0) begin failures++; $display("FAIL reset_cnt got %h exp 0", fu_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (fu_mask !== 24'h0) begin failures++; $display("FAIL reset_data got %h exp 0", fu_mask); end
        checks++; if (mready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", mready); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_push();
`ifdef ARA_MASK_BYPASS_EN
        fu_ready = 3'b010;
        tag = 2'd1; mask = 8'hA5; mvalid = 1'b1;
        #1;
        checks++; if (fu_valid !== 3'b010) begin failures++; $display("FAIL byp_valid got %b exp 010", fu_valid); end
        checks++; if (fu_mask[1] !== 8'hA5) begin failures++; $display("FAIL byp_data got %h exp a5", fu_mask[1]); end
        @(posedge clk); #1;
        mvalid = 1'b0; fu_ready = '0;
        #1;
        checks++; if (fu_cnt[1] !== 2'd0) begin failures++; $display("FAIL byp_cnt got %0d exp 0", fu_cnt[1]); end
`else
        fu_ready = '0;
        push_beat(2'd1, 8'hA5);
        checks++; if (fu_valid !== 3'b010) begin failures++; $display("FAIL single_valid got %b exp 010", fu_valid); end
        checks++; if (fu_mask[1] !== 8'hA5) begin failures++; $display("FAIL single_data got %h exp a5", fu_mask[1]); end
        checks++; if (fu_cnt[1] !== 2'd1) begin failures++; $display("FAIL single_cnt got %0d exp 1", fu_cnt[1]); end
        fu_ready = 3'b010;
        step();
        fu_ready = '0;
        checks++; if (fu_valid !== 3'b000) begin failures++; $display("FAIL single_drain got %b exp 000", fu_valid); end
`endif
    endtask

    task automatic test_backpressure();
        fu_ready = '0;
        push_beat(2'd0, 8'h11);
        push_beat(2'd0, 8'h22);
        checks++; if (fu_cnt[0] !== 2'd2) begin failures++; $display("FAIL bp_cnt_full got %0d exp 2", fu_cnt[0]); end
        tag = 2'd0; mask = 8'h33; mvalid = 1'b1;
        #1;
        checks++; if (mready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got %b exp 0", mready); end
        @(posedge clk); #2;
        checks++; if (fu_cnt[0] !== 2'd2 || fu_mask[0] !== 8'h11) begin failures++; $display("FAIL bp_hold got cnt %0d data %h exp 2 11", fu_cnt[0], fu_mask[0]); end
        tag = 2'd1; mask = 8'h44;
        #1;
        checks++; if (mready !== 1'b1) begin failures++; $display("FAIL bp_other_ready got %b exp 1", mready); end
        @(posedge clk); #1;
        tag = 2'd0; mask = 8'h33; fu_ready = 3'b001;
        #1;
        checks++; if (fu_cnt[1] !== 2'd1 || fu_mask[1] !== 8'h44) begin failures++; $display("FAIL bp_other_push got cnt %0d data %h exp 1 44", fu_cnt[1], fu_mask[1]); end
        checks++; if (mready !== 1'b0) begin failures++; $display("FAIL bp_no_pop_bypass got %b exp 0", mready); end
        @(posedge clk); #1;
        fu_ready = '0;
        #1;
        checks++; if (mready !== 1'b1 || fu_mask[0] !== 8'h22) begin failures++; $display("FAIL bp_after_pop got rdy %b data %h exp 1 22", mready, fu_mask[0]); end
        @(posedge clk); #1;
        mvalid = 1'b0; fu_ready = 3'b001;
        #1;
        checks++; if (fu_cnt[0] !== 2'd2) begin failures++; $display("FAIL bp_third_in got %0d exp 2", fu_cnt[0]); end
        step();
        fu_ready = '0;
        checks++; if (fu_mask[0] !== 8'h33) begin failures++; $display("FAIL bp_order got %h exp 33", fu_mask[0]); end
        fu_flush = 3'b011;
        step();
        fu_flush = '0;
        checks++; if (fu_cnt !== 6'h0) begin failures++; $display("FAIL bp_flush_all got %h exp 0", fu_cnt); end
    endtask

    task automatic test_push_pop();
        fu_ready = '0;
        push_beat(2'd0, 8'h01);
        fu_ready = 3'b001;
        tag = 2'd0; mask = 8'h02; mvalid = 1'b1;
        #1;
        checks++; if (fu_mask[0] !== 8'h01) begin failures++; $display("FAIL pp_head got %h exp 01", fu_mask[0]); end
        @(posedge clk); #1;
        mvalid = 1'b0;
        #1;
        checks++; if (fu_cnt[0] !== 2'd1 || fu_mask[0] !== 8'h02) begin failures++; $display("FAIL pp_same got cnt %0d data %h exp 1 02", fu_cnt[0], fu_mask[0]); end
        step();
        fu_ready = '0;
        checks++; if (fu_cnt[0] !== 2'd0 || fu_valid[0] !== 1'b0) begin failures++; $display("FAIL pp_drain got cnt %0d vld %b exp 0 0", fu_cnt[0], fu_valid[0]); end
    endtask

    task automatic test_flush();
        fu_ready = '0;
        push_beat(2'd0, 8'h55);
        push_beat(2'd1, 8'h66);
        push_beat(2'd1, 8'h77);
        fu_flush = 3'b010;
        tag = 2'd1; mask = 8'h88; mvalid = 1'b1;
        #1;
        checks++; if (mready !== 1'b0) begin failures++; $display("FAIL fl_full_ready got %b exp 0", mready); end
        @(posedge clk); #1;
        mvalid = 1'b0; fu_flush = '0;
        #1;
        checks++; if (fu_cnt[1] !== 2'd0 || fu_valid[1] !== 1'b0) begin failures++; $display("FAIL fl_clear got cnt %0d vld %b exp 0 0", fu_cnt[1], fu_valid[1]); end
        checks++; if (fu_cnt[0] !== 2'd1 || fu_mask[0] !== 8'h55) begin failures++; $display("FAIL fl_other got cnt %0d data %h exp 1 55", fu_cnt[0], fu_mask[0]); end
        push_beat(2'd1, 8'h66);
        fu_flush = 3'b010;
        tag = 2'd1; mask = 8'h88; mvalid = 1'b1;
        #1;
        checks++; if (mready !== 1'b1) begin failures++; $display("FAIL fl_push_ready got %b exp 1", mready); end
        @(posedge clk); #1;
        mvalid = 1'b0; fu_flush = '0;
        #1;
        step();
        checks++; if (fu_valid[1] !== 1'b0 || fu_cnt[1] !== 2'd0) begin failures++; $display("FAIL fl_discard got vld %b cnt %0d exp 0 0", fu_valid[1], fu_cnt[1]); end
        checks++; if (fu_cnt[0] !== 2'd1) begin failures++; $display("FAIL fl_iso got %0d exp 1", fu_cnt[0]); end
        fu_flush = 3'b001;
        step();
        fu_flush = '0;
    endtask

    task automatic test_illegal_tag();
        tag = 2'd3; mask = 8'h99; mvalid = 1'b1;
        #1;
        checks++; if (mready !== 1'b1) begin failures++; $display("FAIL ill_ready got %b exp 1", mready); end
        @(posedge clk); #1;
        mvalid = 1'b0;
        #1;
        checks++; if (fu_valid !== 3'b000 || fu_cnt !== 6'h0) begin failures++; $display("FAIL ill_drop got vld %b cnt %h exp 000 0", fu_valid, fu_cnt); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err got %b exp 1", err); end
        step(); step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_sticky got %b exp 1", err); end
    endtask

    task automatic test_reset_mid();
        fu_ready = '0;
        push_beat(2'd0, 8'hC1);
        push_beat(2'd0, 8'hC2);
        push_beat(2'd1, 8'hD1);
        push_beat(2'd1, 8'hD2);
        checks++; if (fu_cnt[0] !== 2'd2 || fu_cnt[1] !== 2'd2) begin failures++; $display("FAIL rm_fill got %h exp full", fu_cnt); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (fu_valid !== 3'b000 || fu_cnt !== 6'h0) begin failures++; $display("FAIL rm_async got vld %b cnt %h exp 000 0", fu_valid, fu_cnt); end
        checks++; if (err !== 1'b0 || fu_mask !== 24'h0) begin failures++; $display("FAIL rm_err_data got err %b data %h exp 0 0", err, fu_mask); end
        step();
        rst_n = 1'b1;
        step();
        tag = 2'd0;
        #1;
        checks++; if (mready !== 1'b1 || fu_valid !== 3'b000) begin failures++; $display("FAIL rm_after got rdy %b vld %b exp 1 000", mready, fu_valid); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_illegal_tag();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vfu_mask_router.md
# vfu_mask_router

Tagged mask-distribution block for the lane's functional-unit stage: one mask beat stream from the mask unit is routed to one of `NrFUs` functional units.
- Selection uses an explicit FU tag, replacing the untagged mask broadcast to ALU and MFPU.
- Each FU channel has its own small FIFO, so masked instructions can be in flight in several FUs at once without cross-acceptance.
- It sits in the lane between the mask unit interface and the FU instances (VALU, VMFPU, future units).

## Interface
Parameters:
- `NrFUs`, default `NrMaskFUnits`: number of FU channels; ≥1.
- `MaskBufDepth`, default 2: per-channel FIFO depth; ≥1.
- `DataWidth`, default `$bits(elen_t)`: element width; `strb_t` is `logic [DataWidth/8-1:0]` (derived, do not override).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `mask_i`  in  `strb_t`  mask beat from the mask unit.
- `mask_fu_i`  in  `idx_width(NrFUs)`  destination FU tag.
- `mask_valid_i`  in  1  beat valid.
- `mask_ready_o`  out  1  beat accepted (together with valid).
- `fu_mask_o`  out  `[NrFUs-1:0]` `strb_t`  per-FU mask data.
- `fu_mask_valid_o`  out  `NrFUs`  per-FU valid.
- `fu_mask_ready_i`  in  `NrFUs`  per-FU ready.
- `fu_flush_i`  in  `NrFUs`  per-FU synchronous flush (instruction abort/done).
- `fu_mask_cnt_o`  out  `[NrFUs-1:0][idx_width(MaskBufDepth+1)-1:0]`  per-channel occupancy.
- `mask_err_o`  out  1  sticky: a beat arrived with tag ≥ `NrFUs`.

## Operation
- Channel state per FU:
  - FIFO of `MaskBufDepth` entries, with read pointer, write pointer and count.
  - Pointers wrap modulo `MaskBufDepth`; non-power-of-two depths are supported by explicit compare-and-clear.
  - Count saturates neither way: pushing when full and popping when empty are impossible by construction.
- Accept rule:
  - `mask_ready_o` = (tag < `NrFUs`) ? !full[tag] : 1.
  - Readiness is not derived from `fu_mask_ready_i`: there is no pop-frees-push path and no combinational path from FU ready to `mask_ready_o`.
- Push: on `mask_valid_i & mask_ready_o` with a legal tag, the beat is written to channel `tag`.
- Illegal tag: the beat is consumed and dropped, and `mask_err_o` sets. It clears only on reset.
- Pop: on `fu_mask_valid_o[i] & fu_mask_ready_i[i]`, the head of channel `i` advances.
- Output: `fu_mask_valid_o[i]` = count[i] ≠ 0, and `fu_mask_o[i]` = head entry. Data is held stable while valid and not ready.
- Simultaneous push and pop on the same channel: both occur and the count is unchanged. Allowed only when the channel is not full.
- Flush `fu_flush_i[i]`:
  - Clears channel `i` pointers and count at the next edge.
  - A same-cycle push to `i` is accepted (ready as normal) and discarded.
  - A same-cycle pop is irrelevant.
  - Flush of one channel never affects the others.
- Ordering: beats are delivered in arrival order within each channel. No ordering is implied across channels.

## Timing
- Reset values:
  - all counts and pointers = 0;
  - `fu_mask_valid_o` = 0;
  - `fu_mask_cnt_o` = 0;
  - `mask_err_o` = 0;
  - `fu_mask_o` = 0;
  - `mask_ready_o` follows its combinational rule (1 while the channel is empty).
- Reset asserted mid-transfer discards all buffered beats immediately.
- Latency without bypass: a beat accepted at edge N is visible on `fu_mask_valid_o` in cycle N+1.
- Throughput: one beat per cycle per router input; each FU can pop one beat per cycle concurrently.
- `fu_mask_cnt_o` is registered and reflects state after the last edge.

## Configuration
- Macro `ARA_MASK_BYPASS_EN`.
- Defined: a channel that is empty and not being flushed forwards `mask_i` combinationally.
  - `fu_mask_valid_o[tag]` = `mask_valid_i`.
  - When `fu_mask_ready_i[tag]` is also high, the beat is consumed without entering the FIFO: 0-cycle latency, and the count is unchanged.
  - When the FU is not ready, the beat is pushed as normal.
  - Adds a combinational path from `mask_valid_i`/`mask_fu_i` to `fu_mask_valid_o`.
- Undefined: registered-only behaviour, 1-cycle latency, no input-to-output combinational paths.

## Structure
- `ara_pkg` holds:
  - `NrMaskFUnits` and the FU index constants (`MaskFUAlu`, `MaskFUMFpu`, new units appended);
  - a `mask_fu_tag_t` typedef of width `idx_width(NrMaskFUnits)`.
- Sub-module `vfu_mask_fifo`: a single-channel FIFO with flush and count output, instantiated `NrFUs` times in a generate loop.
- The top level contains the tag decode, the ready mux, the error flag and the optional bypass.

## Test plan
- Reset and single push: `NrFUs`=2, depth 2; send `mask_i`=0xA5, tag 1 → cycle N+1: `fu_mask_valid_o`=2'b10, `fu_mask_o[1]`=0xA5, `fu_mask_cnt_o[1]`=1. With bypass compiled in and `fu_mask_ready_i[1]`=1 → same cycle, count stays 0.
- Backpressure on one channel: hold `fu_mask_ready_i[0]`=0 and push 3 beats to tag 0 → third beat sees `mask_ready_o`=0 until a pop. Meanwhile a beat to tag 1 is accepted immediately.
- Simultaneous push and pop: channel 0 count=1 with FU ready, push in the same cycle → count stays 1 and data order is preserved (0x01 then 0x02).
- Flush during push: channel 1 holds 2 beats; assert `fu_flush_i[1]` with a push to tag 1 → next cycle count=0, valid=0, the pushed beat is never delivered, and channel 0 is untouched.
- Illegal tag: `NrFUs`=3, tag 3 → accepted, no channel valid, `mask_err_o`=1 until `rst_ni` low.
- Reset mid-stream: assert `rst_ni`=0 with both channels full → all valids and counts are 0 asynchronously, before the next edge.
